mc_control: RTL
===============

Name: mc_control

Overview:
- Multicycle main control FSM for the custom MIPS core.
- Sequences fetch, decode, execute, memory and writeback over the shared single ALU, register file and unified memory port.
- Drives the 2-bit aluop pair consumed by the ALU function decoder, plus all datapath mux selects and write enables.
- Waits on a memory-ready handshake, with a timeout counter that traps on a hung memory access.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent waiting for mem_ready in one memory state before trapping; 0 disables the timeout.
- TMO_W, 4: width of the wait counter; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  6  opcode, ir[31:26]; only sampled in DECODE
- mem_ready  in  1  memory access completes this cycle
- pcwrite  out  1  unconditional PC write
- pcwritecond  out  1  PC write if branch condition holds
- branch_ne  out  1  branch condition is not-zero (bne)
- iord  out  1  memory address mux: 0 = PC, 1 = ALUOut
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regdst  out  1  destination register: 1 = rd, 0 = rt
- memtoreg  out  1  writeback mux: 1 = MDR, 0 = ALUOut
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A mux: 0 = PC, 1 = reg A
- alusrcb  out  2  ALU B mux: 00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm << 2
- pcsource  out  2  PC mux: 00 = ALU, 01 = ALUOut, 10 = jump target
- aluop1  out  1  R-type: decode funct
- aluop0  out  1  branch: subtract
- trap  out  1  sticky error flag
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout

Behaviour:
- Encoding: 4-bit state register, Moore outputs decoded from state.
- Reset: state = FETCH, wait counter = 0, trap = 0, trap_cause = 00. All combinational outputs follow FETCH decode.
- Every output is 0 unless listed for the state below. aluop = 00 means add; aluop0 = 1 means subtract.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00. irwrite and pcwrite equal mem_ready. Go to DECODE on mem_ready, otherwise stay.
- DECODE: alusrca=0, alusrcb=11, aluop=00, computing the branch target into ALUOut. Next state by op:
  - 000000 -> RTYPE_EX
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDI_EX
  - 000010 (j) -> JUMP
  - anything else -> TRAP, cause 01
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEMRD if op[3]=0, MEMWR if op[3]=1.
- MEMRD: memread=1, iord=1. Go to MEMWB on mem_ready.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Go to FETCH.
- MEMWR: memwrite=1, iord=1. Hold memwrite until mem_ready, then go to FETCH.
- RTYPE_EX: alusrca=1, alusrcb=00, aluop=10. Go to RTYPE_WB.
- RTYPE_WB: regwrite=1, regdst=1, memtoreg=0. Go to FETCH.
- ADDI_EX: alusrca=1, alusrcb=10, aluop=00. Go to ADDI_WB.
- ADDI_WB: regwrite=1, regdst=0, memtoreg=0. Go to FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01, branch_ne=op[0]. Go to FETCH.
- JUMP: pcwrite=1, pcsource=10. Go to FETCH.
- TRAP: all strobes 0, trap=1. Stays in TRAP until reset.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle spent in one of those states with mem_ready=0.
  - When counter == MEM_TIMEOUT with mem_ready still 0 (and MEM_TIMEOUT != 0), go to TRAP with cause 10.
  - mem_ready=1 in that same cycle wins: no trap.
- Reset mid-instruction (any state, including TRAP): return to FETCH next cycle. No write strobe is asserted in the reset cycle's decoded output.
- Undefined state encodings go to FETCH.

Optional Feature:
- Macro MC_CONTROL_BNE_EN.
- Defined: op 000101 (bne) decodes to BRANCH with branch_ne=1.
- Undefined: 000101 traps as an illegal opcode, and branch_ne is tied to 0.

Decomposition:
- Package mc_pkg holds:
  - state enum/localparams
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J
  - aluop constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - alusrcb and pcsource select codes
  - trap cause codes
- Sub-module mc_mem_wait: wait counter plus timeout compare. It takes the in_mem_state and mem_ready inputs and produces a timeout pulse.
- Output decode stays in mc_control.

Test Plan:
- R-type, op=000000, mem_ready=1 always -> states FETCH, DECODE, RTYPE_EX, RTYPE_WB, FETCH (4 cycles). aluop=10 in RTYPE_EX; regwrite=1 with regdst=1 in RTYPE_WB.
- lw, op=100011, mem_ready low 3 cycles in MEMRD -> memread/iord held 4 cycles, then MEMWB with regwrite=1 and memtoreg=1. Total 5 + 3 cycles.
- sw, op=101011 -> MEMWR with memwrite=1, iord=1, regwrite never asserted. beq, op=000100 -> BRANCH with aluop=01, pcwritecond=1, pcsource=01, branch_ne=0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> trap=1 and trap_cause=10 on the 16th cycle. With mem_ready=1 exactly on the 16th cycle -> DECODE, no trap.
- op=111111 -> TRAP with cause 01, sticky for 20 cycles. Reset pulse -> FETCH, trap=0. op=000101 -> BRANCH with branch_ne=1 when MC_CONTROL_BNE_EN is defined, TRAP cause 01 when not.
- Reset asserted in MEMWR while mem_ready=0 -> next cycle FETCH, memwrite=0, wait counter=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS main control: state encoding,
// opcodes, ALU/mux select codes and trap causes.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      RTYPE_EX = 4'd6,
      RTYPE_WB = 4'd7,
      ADDI_EX  = 4'd8,
      ADDI_WB  = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11,
      TRAP     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   // States that sit on the unified memory port waiting for mem_ready.
   function automatic logic is_mem_state(input state_t s);
      return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
   endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory-ready wait counter; pulses timeout when a memory state has waited
// MEM_TIMEOUT cycles and mem_ready is still low (MEM_TIMEOUT = 0 disables).
module mc_mem_wait #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TMO_W       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic in_mem_state,
   input  logic mem_ready,
   output logic timeout
);

   localparam logic             TMO_EN = (MEM_TIMEOUT != 0);
   localparam logic [TMO_W-1:0] LIMIT  = TMO_W'(MEM_TIMEOUT);

   logic [TMO_W-1:0] count_reg;
   logic [TMO_W-1:0] count_next;

   // Every exit from a memory state is either mem_ready or a trap, so clearing
   // on "not waiting" gives a zero count on entry to the next memory state.
   always_comb begin
      count_next = count_reg;
      if (!in_mem_state || mem_ready) begin
         count_next = '0;
      end else if (count_reg != '1) begin
         count_next = count_reg + TMO_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign timeout = TMO_EN && in_mem_state && !mem_ready && (count_reg == LIMIT);

endmodule

// File: rtl/mc_control.sv
// Multicycle main control FSM (Moore outputs decoded from state).
// Optional: define MC_CONTROL_BNE_EN to decode bne into BRANCH with branch_ne=1.
module mc_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TMO_W       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       pcwritecond,
   output logic       branch_ne,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsource,
   output logic       aluop1,
   output logic       aluop0,
   output logic       trap,
   output logic [1:0] trap_cause
);
   import mc_pkg::*;

   state_t     state_reg;
   state_t     state_next;
   logic       trap_reg;
   logic [1:0] cause_reg;
   logic [1:0] cause_next;
   logic       timeout;
   logic [1:0] aluop;

   mc_mem_wait #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .TMO_W      (TMO_W)
   ) u_wait (
      .clk         (clk),
      .reset       (reset),
      .in_mem_state(is_mem_state(state_reg)),
      .mem_ready   (mem_ready),
      .timeout     (timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= FETCH;
         trap_reg  <= 1'b0;
         cause_reg <= CAUSE_NONE;
      end else begin
         state_reg <= state_next;
         trap_reg  <= (state_next == TRAP);
         cause_reg <= cause_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cause_next = cause_reg;
      case (state_reg)
         FETCH: begin
            if (mem_ready) begin
               state_next = DECODE;
            end else if (timeout) begin
               state_next = TRAP;
               cause_next = CAUSE_TIMEOUT;
            end
         end
         DECODE: begin
            case (op)
               OP_RTYPE:     state_next = RTYPE_EX;
               OP_LW, OP_SW: state_next = MEMADR;
               OP_BEQ:       state_next = BRANCH;
`ifdef MC_CONTROL_BNE_EN
               OP_BNE:       state_next = BRANCH;
`endif
               OP_ADDI:      state_next = ADDI_EX;
               OP_J:         state_next = JUMP;
               default: begin
                  state_next = TRAP;
                  cause_next = CAUSE_ILLEGAL;
               end
            endcase
         end
         MEMADR:   state_next = op[3] ? MEMWR : MEMRD;
         MEMRD: begin
            if (mem_ready) begin
               state_next = MEMWB;
            end else if (timeout) begin
               state_next = TRAP;
               cause_next = CAUSE_TIMEOUT;
            end
         end
         MEMWB:    state_next = FETCH;
         MEMWR: begin
            if (mem_ready) begin
               state_next = FETCH;
            end else if (timeout) begin
               state_next = TRAP;
               cause_next = CAUSE_TIMEOUT;
            end
         end
         RTYPE_EX: state_next = RTYPE_WB;
         RTYPE_WB: state_next = FETCH;
         ADDI_EX:  state_next = ADDI_WB;
         ADDI_WB:  state_next = FETCH;
         BRANCH:   state_next = FETCH;
         JUMP:     state_next = FETCH;
         TRAP:     state_next = TRAP;
         default:  state_next = FETCH;
      endcase
   end

   always_comb begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      branch_ne   = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      regdst      = 1'b0;
      memtoreg    = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = SRCB_B;
      pcsource    = PCSRC_ALU;
      aluop       = ALUOP_ADD;
      case (state_reg)
         FETCH: begin
            memread = 1'b1;
            alusrcb = SRCB_FOUR;
            irwrite = mem_ready;
            pcwrite = mem_ready;
         end
         DECODE:  alusrcb = SRCB_IMM_SH2;
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
         end
         RTYPE_EX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         RTYPE_WB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         ADDI_EX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         ADDI_WB:  regwrite = 1'b1;
         BRANCH: begin
            alusrca     = 1'b1;
            aluop       = ALUOP_SUB;
            pcwritecond = 1'b1;
            pcsource    = PCSRC_ALUOUT;
`ifdef MC_CONTROL_BNE_EN
            branch_ne   = op[0];
`endif
         end
         JUMP: begin
            pcwrite  = 1'b1;
            pcsource = PCSRC_JUMP;
         end
         default: ;
      endcase
      // A reset arriving mid-instruction must not commit any architectural write.
      if (reset) begin
         pcwrite     = 1'b0;
         pcwritecond = 1'b0;
         memwrite    = 1'b0;
         irwrite     = 1'b0;
         regwrite    = 1'b0;
      end
   end

   assign aluop1     = aluop[1];
   assign aluop0     = aluop[0];
   assign trap       = trap_reg;
   assign trap_cause = cause_reg;

endmodule
